// File: rtl/mos_la_snapshot_reader.sv
// mos_la_snapshot_reader
//   Captures a wide decoder result into a snapshot register and serves it to
//   the logic analyzer as WORD_W-bit words. Once a read sequence starts, the
//   snapshot is frozen until rd_done_i, so multi-word readback is coherent.
//
// Ports
//   wb_clk_i        clock, rising edge
//   wb_rst_i        synchronous active-high reset
//   result_i        decoder result (IN_W bits)
//   result_valid_i  one-cycle capture strobe for result_i
//   rd_req_i        read request pulse
//   rd_auto_i       1: read word[pointer] and advance; 0: read word[rd_idx_i]
//   rd_idx_i        manual word index
//   rd_done_i       ends the read sequence and releases the snapshot
//   clr_i           clears the sticky flags
//   rd_data_o       registered read word
//   rd_ack_o        one-cycle pulse, rd_data_o valid
//   rd_last_o       with rd_ack_o: the word returned was index NWORDS-1
//   snap_full_o     snapshot holds unread or in-progress data
//   overrun_o       sticky: a capture was dropped or overwrote unread data
//   idx_err_o       sticky: a manual index was >= NWORDS
//
// Handshake: rd_req_i is sampled on a rising edge; exactly one cycle later
// rd_ack_o pulses for one cycle with rd_data_o/rd_last_o valid. There is no
// backpressure; back-to-back requests give back-to-back acks.

module mos_la_snapshot_reader #(
  parameter  int IN_W   = 66,
  parameter  int WORD_W = 32,
  localparam int NWORDS = (IN_W + WORD_W - 1) / WORD_W,
  localparam int IDX_W  = $clog2(NWORDS + 1)
) (
`ifdef USE_POWER_PINS
  inout  wire               vdd,
  inout  wire               vss,
`endif
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [IN_W-1:0]   result_i,
  input  logic              result_valid_i,
  input  logic              rd_req_i,
  input  logic              rd_auto_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic              rd_done_i,
  input  logic              clr_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_ack_o,
  output logic              rd_last_o,
  output logic              snap_full_o,
  output logic              overrun_o,
  output logic              idx_err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_READING = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [IN_W-1:0]     snap_q,    snap_d;
  logic [IDX_W-1:0]    ptr_q,     ptr_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_ack_q,  rd_ack_d;
  logic                rd_last_q, rd_last_d;
  logic                overrun_q, overrun_d;
  logic                idx_err_q, idx_err_d;

  logic [NWORDS*WORD_W-1:0] snap_pad;
  logic [IDX_W-1:0]         rd_sel;
  logic                     sel_ok;
  logic [WORD_W-1:0]        word_sel;
  logic                     serve;

  // Zero-extend the snapshot to a whole number of words so the top word is
  // padded with zeros above bit IN_W-1.
  always_comb begin
    snap_pad            = '0;
    snap_pad[IN_W-1:0]  = snap_q;
  end

  // Word selection; an index >= NWORDS selects nothing (sel_ok = 0).
  always_comb begin
    rd_sel   = rd_auto_i ? ptr_q : rd_idx_i;
    sel_ok   = (rd_sel < IDX_W'(NWORDS));
    word_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (rd_sel == IDX_W'(k)) word_sel = snap_pad[k*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    rd_last_d = 1'b0;
    overrun_d = overrun_q;
    idx_err_d = idx_err_q;
    serve     = 1'b0;

    // Clear first so that any set event below in the same cycle wins.
    if (clr_i) begin
      overrun_d = 1'b0;
      idx_err_d = 1'b0;
    end

    case (state_q)
      ST_EMPTY: begin
        // Nothing captured yet: acknowledge with zero data.
        if (rd_req_i) begin
          rd_ack_d  = 1'b1;
          rd_data_d = '0;
        end
        if (result_valid_i) begin
          snap_d  = result_i;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (result_valid_i) overrun_d = 1'b1;
        // A read in the same cycle as a capture returns the old snapshot and
        // the new value is dropped, because the sequence locks the snapshot.
        if (rd_req_i) begin
          serve   = 1'b1;
          state_d = ST_READING;
        end else if (result_valid_i) begin
          snap_d = result_i;
        end
      end
      ST_READING: begin
        if (result_valid_i) overrun_d = 1'b1;
        // rd_done_i wins over a same-cycle request: no ack.
        if (rd_done_i) begin
          ptr_d   = '0;
          state_d = ST_EMPTY;
        end else if (rd_req_i) begin
          serve = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (serve) begin
      rd_ack_d  = 1'b1;
      rd_data_d = sel_ok ? word_sel : '0;
      rd_last_d = sel_ok && (rd_sel == IDX_W'(NWORDS - 1));
      if (rd_auto_i) begin
        ptr_d = (ptr_q == IDX_W'(NWORDS - 1)) ? '0 : ptr_q + IDX_W'(1);
      end else if (!sel_ok) begin
        idx_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_EMPTY;
      snap_q    <= '0;
      ptr_q     <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      rd_last_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      rd_last_q <= rd_last_d;
      overrun_q <= overrun_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_ack_o    = rd_ack_q;
  assign rd_last_o   = rd_last_q;
  assign overrun_o   = overrun_q;
  assign idx_err_o   = idx_err_q;
  assign snap_full_o = (state_q != ST_EMPTY);

endmodule

// File: tb/tb_mos_la_snapshot_reader.sv
// Testbench for mos_la_snapshot_reader: directed scenarios followed by
// randomized traffic, checked against a behavioural model through a
// scoreboard of expected read words and per-cycle expected flags.

module tb_mos_la_snapshot_reader;

  localparam int IN_W   = 66;
  localparam int WORD_W = 32;
  localparam int NWORDS = 3;
  localparam int IDX_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [IN_W-1:0]   result;
  logic              result_valid;
  logic              rd_req;
  logic              rd_auto;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_done;
  logic              clr;
  logic [WORD_W-1:0] rd_data_o;
  logic              rd_ack_o;
  logic              rd_last_o;
  logic              snap_full_o;
  logic              overrun_o;
  logic              idx_err_o;

  mos_la_snapshot_reader dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .result_i       (result),
    .result_valid_i (result_valid),
    .rd_req_i       (rd_req),
    .rd_auto_i      (rd_auto),
    .rd_idx_i       (rd_idx),
    .rd_done_i      (rd_done),
    .clr_i          (clr),
    .rd_data_o      (rd_data_o),
    .rd_ack_o       (rd_ack_o),
    .rd_last_o      (rd_last_o),
    .snap_full_o    (snap_full_o),
    .overrun_o      (overrun_o),
    .idx_err_o      (idx_err_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W:0] exp_q[$];   // {last, data} per expected ack
  logic [3:0]      flag_q[$];  // {ack, full, overrun, idx_err} per cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A snapshot either is absent, present, or locked by a read sequence.
  bit              m_have;
  bit              m_locked;
  logic [IN_W-1:0] m_snap;
  int              m_ptr;
  bit              m_ovr;
  bit              m_idxe;

  function automatic logic [WORD_W-1:0] word_of(input int k);
    logic [IN_W-1:0] s;
    s = m_snap >> (WORD_W * k);
    return s[WORD_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [IN_W-1:0] val, input bit req,
                       input bit aut, input int idx, input bit done, input bit c);
    bit              ack;
    bit              last;
    logic [WORD_W-1:0] d;
    bit              srv;
    int              k;
    result_valid = v;
    result       = val;
    rd_req       = req;
    rd_auto      = aut;
    rd_idx       = IDX_W'(idx);
    rd_done      = done;
    clr          = c;

    ack = 0; last = 0; d = '0; srv = 0;
    if (c) begin m_ovr = 0; m_idxe = 0; end
    if (!m_have) begin
      if (req) ack = 1;
      if (v) begin m_snap = val; m_have = 1; end
    end else if (!m_locked) begin
      if (v) m_ovr = 1;
      if (req) begin srv = 1; m_locked = 1; end
      else if (v) m_snap = val;
    end else begin
      if (v) m_ovr = 1;
      if (done) begin m_ptr = 0; m_have = 0; m_locked = 0; end
      else if (req) srv = 1;
    end
    if (srv) begin
      ack = 1;
      k = aut ? m_ptr : idx;
      if (k < NWORDS) begin
        d    = word_of(k);
        last = (k == NWORDS - 1);
      end else begin
        m_idxe = 1;
      end
      if (aut) m_ptr = (m_ptr + 1) % NWORDS;
    end

    @(posedge clk);
    #1;
    if (ack) exp_q.push_back({last, d});
    flag_q.push_back({ack, m_have, m_ovr, m_idxe});
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit req);
    rst = 1; result_valid = 0; result = '0; rd_req = req; rd_auto = 1;
    rd_idx = '0; rd_done = 0; clr = 0;
    m_have = 0; m_locked = 0; m_snap = '0; m_ptr = 0; m_ovr = 0; m_idxe = 0;
    @(posedge clk);
    #1;
    rst = 0; rd_req = 0;
    check("reset_rd_data", 64'(rd_data_o), 64'd0);
    flag_q.push_back(4'b0000);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0]      f;
    logic [WORD_W:0] e;
    if (flag_q.size() > 0) begin
      f = flag_q.pop_front();
      check("rd_ack",      64'(rd_ack_o),    64'(f[3]));
      check("snap_full",   64'(snap_full_o), 64'(f[2]));
      check("overrun",     64'(overrun_o),   64'(f[1]));
      check("idx_err",     64'(idx_err_o),   64'(f[0]));
    end
    if (rd_ack_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got data %0h, expected no ack", rd_data_o);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 64'(rd_data_o), 64'(e[WORD_W-1:0]));
        check("rd_last", 64'(rd_last_o), 64'(e[WORD_W]));
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [IN_W-1:0] V0 = 66'h2_DEADBEEF_CAFEF00D;
  localparam logic [IN_W-1:0] V1 = 66'h1_11112222_33334444;
  localparam logic [IN_W-1:0] V2 = 66'h3_55556666_77778888;
  localparam logic [IN_W-1:0] V3 = 66'h0_9999AAAA_BBBBCCCC;
  localparam logic [IN_W-1:0] V4 = 66'h2_0F0F0F0F_F0F0F0F0;

  initial begin
    logic [95:0] rnd;
    do_reset(0);
    idle();

    // Capture and auto-read all three words.
    cycle(1, V0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 1, 0, 0, 0);
    // Manual reads including an out-of-range index, then clear.
    cycle(0, '0, 1, 0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0, 0, 0);
    cycle(0, '0, 1, 0, 3, 0, 0);
    cycle(0, '0, 0, 0, 0, 0, 1);
    // Capture strobe while reading is dropped; old words still returned.
    cycle(1, V1, 0, 0, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 2, 0, 0);
    // rd_done beats a same-cycle request; new capture is then readable.
    cycle(0, '0, 1, 1, 0, 1, 0);
    cycle(1, V1, 0, 0, 0, 0, 1);
    cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1, 0);
    // Capture and read in the same cycle in FULL: old word, overrun.
    cycle(1, V2, 0, 0, 0, 0, 0);
    cycle(1, V3, 1, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1, 1);
    // Overwrite in FULL, then four auto reads to show wrap.
    cycle(1, V3, 0, 0, 0, 0, 0);
    cycle(1, V4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1, 0);
    // Read while empty.
    cycle(0, '0, 1, 1, 0, 0, 0);
    // Reset mid-sequence (with a request pending), then restart at word 0.
    cycle(1, V2, 0, 0, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0, 0);
    do_reset(1);
    cycle(1, V1, 0, 0, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit v, req, aut, done, c;
      int idx;
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        rnd  = {$urandom, $urandom, $urandom};
        v    = ($urandom_range(0, 3) == 0);
        req  = ($urandom_range(0, 1) == 1);
        aut  = m_have ? ($urandom_range(0, 1) == 1) : 1'b1;
        idx  = $urandom_range(0, 3);
        done = m_locked && ($urandom_range(0, 4) == 0);
        c    = ($urandom_range(0, 7) == 0);
        cycle(v, rnd[IN_W-1:0], req, aut, idx, done, c);
      end
    end

    idle();
    idle();
    @(posedge clk);
    #1;
    check("pending_acks", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
